// File: rtl/i2c_slave.sv
// I2C target with 7-bit address, byte read/write, repeated START and burst reads.
// Define I2C_SLAVE_GENERAL_CALL_EN to also acknowledge general-call writes to address 7'h00.
module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
    input  logic       iw_clk,
    input  logic       iw_reset,
    inout  wire        io_i2c_sda,
    input  logic       iw_i2c_scl,
    input  logic [7:0] iw_tx_data,
    output logic       ow_tx_req,
    output logic [7:0] ow_rx_data,
    output logic       ow_rx_valid,
    output logic       ow_busy
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ACK_ADDR, RX_DATA, ACK_RX, TX_DATA, WAIT_ACK, IGNORE
    } state_t;

    state_t     state, state_next;
    logic [3:0] bit_cnt, bit_cnt_next;
    logic [7:0] shift, shift_next;
    logic       sda_oe, sda_oe_next;
    logic       rw, rw_next;
    logic [7:0] rx_data_next;
    logic       rx_valid_next, tx_req_next, busy_next;

    logic scl_meta, scl_sync, scl_prev;
    logic sda_meta, sda_sync, sda_prev;

    // NOTE: synchronizers reset to 1 (idle bus) so leaving reset never fakes a START or STOP.
    always_ff @(posedge iw_clk) begin
        if (iw_reset) begin
            scl_meta <= 1'b1;
            scl_sync <= 1'b1;
            scl_prev <= 1'b1;
            sda_meta <= 1'b1;
            sda_sync <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_meta <= iw_i2c_scl;
            scl_sync <= scl_meta;
            scl_prev <= scl_sync;
            sda_meta <= io_i2c_sda;
            sda_sync <= sda_meta;
            sda_prev <= sda_sync;
        end
    end

    logic       scl_rise, scl_fall, start_det, stop_det, addr_match;
    logic [7:0] byte_in;

    assign scl_rise  = scl_sync & ~scl_prev;
    assign scl_fall  = ~scl_sync & scl_prev;
    assign start_det = scl_sync & scl_prev & sda_prev & ~sda_sync;
    assign stop_det  = scl_sync & scl_prev & ~sda_prev & sda_sync;
    assign byte_in   = {shift[6:0], sda_sync};

`ifdef I2C_SLAVE_GENERAL_CALL_EN
    assign addr_match = (byte_in[7:1] == SLAVE_ADDR) || (byte_in == 8'h00);
`else
    assign addr_match = (byte_in[7:1] == SLAVE_ADDR);
`endif

    assign io_i2c_sda = sda_oe ? 1'b0 : 1'bz;

    // NOTE: state and datapath registers use non-blocking assignments only.
    always_ff @(posedge iw_clk) begin
        if (iw_reset) begin
            state       <= IDLE;
            bit_cnt     <= 4'd0;
            shift       <= 8'h00;
            sda_oe      <= 1'b0;
            rw          <= 1'b0;
            ow_rx_data  <= 8'h00;
            ow_rx_valid <= 1'b0;
            ow_tx_req   <= 1'b0;
            ow_busy     <= 1'b0;
        end else begin
            state       <= state_next;
            bit_cnt     <= bit_cnt_next;
            shift       <= shift_next;
            sda_oe      <= sda_oe_next;
            rw          <= rw_next;
            ow_rx_data  <= rx_data_next;
            ow_rx_valid <= rx_valid_next;
            ow_tx_req   <= tx_req_next;
            ow_busy     <= busy_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    always_comb begin
        state_next    = state;
        bit_cnt_next  = bit_cnt;
        shift_next    = shift;
        sda_oe_next   = sda_oe;
        rw_next       = rw;
        rx_data_next  = ow_rx_data;
        rx_valid_next = 1'b0;
        tx_req_next   = 1'b0;
        busy_next     = ow_busy;

        if (stop_det) begin
            state_next  = IDLE;
            sda_oe_next = 1'b0;
            busy_next   = 1'b0;
        end else if (start_det) begin
            state_next   = ADDR;
            bit_cnt_next = 4'd0;
            sda_oe_next  = 1'b0;
        end else begin
            case (state)
                ADDR: if (scl_rise) begin
                    shift_next = byte_in;
                    if (bit_cnt == 4'd7) begin
                        bit_cnt_next = 4'd0;
                        rw_next      = byte_in[0];
                        busy_next    = addr_match;
                        state_next   = addr_match ? ACK_ADDR : IGNORE;
                    end else begin
                        bit_cnt_next = bit_cnt + 4'd1;
                    end
                end
                // First SCL fall starts the ACK, the second ends it.
                ACK_ADDR: if (scl_fall) begin
                    if (!sda_oe) begin
                        sda_oe_next = 1'b1;
                    end else if (rw) begin
                        shift_next   = {iw_tx_data[6:0], 1'b0};
                        sda_oe_next  = ~iw_tx_data[7];
                        bit_cnt_next = 4'd1;
                        tx_req_next  = 1'b1;
                        state_next   = TX_DATA;
                    end else begin
                        sda_oe_next  = 1'b0;
                        bit_cnt_next = 4'd0;
                        state_next   = RX_DATA;
                    end
                end
                RX_DATA: if (scl_rise) begin
                    shift_next = byte_in;
                    if (bit_cnt == 4'd7) begin
                        bit_cnt_next  = 4'd0;
                        rx_data_next  = byte_in;
                        rx_valid_next = 1'b1;
                        state_next    = ACK_RX;
                    end else begin
                        bit_cnt_next = bit_cnt + 4'd1;
                    end
                end
                ACK_RX: if (scl_fall) begin
                    sda_oe_next = ~sda_oe;
                    if (sda_oe) state_next = RX_DATA;
                end
                // bit_cnt counts bits already placed on the bus; 8 means bit 0 is out.
                TX_DATA: if (scl_fall) begin
                    if (bit_cnt == 4'd8) begin
                        sda_oe_next  = 1'b0;
                        bit_cnt_next = 4'd0;
                        state_next   = WAIT_ACK;
                    end else begin
                        sda_oe_next  = ~shift[7];
                        shift_next   = {shift[6:0], 1'b0};
                        bit_cnt_next = bit_cnt + 4'd1;
                    end
                end
                WAIT_ACK: if (scl_rise) begin
                    if (!sda_sync) begin
                        shift_next   = iw_tx_data;
                        bit_cnt_next = 4'd0;
                        tx_req_next  = 1'b1;
                        state_next   = TX_DATA;
                    end else begin
                        state_next = IGNORE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_slave.sv
// Self-checking bench for i2c_slave: directed scenarios plus randomized transfers
// scored against a transaction-level model of what the target should acknowledge and return.
module tb_i2c_slave;

    localparam int         Q    = 5;
    localparam logic [6:0] SADR = 7'h50;

    logic       clk = 1'b0;
    logic       reset;
    logic       scl;
    logic       m_low;
    logic [7:0] tx_data;
    logic       tx_req, rx_valid, busy;
    logic [7:0] rx_data;
    wire        sda;

    pullup (sda);
    assign sda = m_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_slave #(.SLAVE_ADDR(SADR)) dut (
        .iw_clk     (clk),
        .iw_reset   (reset),
        .io_i2c_sda (sda),
        .iw_i2c_scl (scl),
        .iw_tx_data (tx_data),
        .ow_tx_req  (tx_req),
        .ow_rx_data (rx_data),
        .ow_rx_valid(rx_valid),
        .ow_busy    (busy)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    int         rx_pulses = 0;
    int         tx_pulses = 0;
    logic       slave_drove = 1'b0;
    logic       busy_seen   = 1'b0;
    logic [7:0] tx_vals[$];

    // Bus monitor: counts pulse cycles, feeds the next read byte after each tx request.
    always @(negedge clk) begin
        if (rx_valid) rx_pulses++;
        if (tx_req) begin
            tx_pulses++;
            if (tx_vals.size() > 0) tx_data = tx_vals.pop_front();
        end
        if (!m_low && sda === 1'b0) slave_drove = 1'b1;
        if (busy) busy_seen = 1'b1;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        m_low = 1'b0; tick(Q);
        scl   = 1'b1; tick(Q);
        m_low = 1'b1; tick(Q);
        scl   = 1'b0; tick(Q);
    endtask

    task automatic bus_stop();
        m_low = 1'b1; tick(Q);
        scl   = 1'b1; tick(Q);
        m_low = 1'b0; tick(Q);
    endtask

    task automatic send_bit(input logic b);
        m_low = ~b; tick(Q);
        scl   = 1'b1; tick(2 * Q);
        scl   = 1'b0; tick(Q);
    endtask

    task automatic recv_bit(output logic b);
        m_low = 1'b0; tick(Q);
        scl   = 1'b1; tick(Q);
        b     = (sda === 1'b0) ? 1'b0 : 1'b1;
        tick(Q);
        scl   = 1'b0; tick(Q);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic acked);
        logic b;
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(b);
        acked = ~b;
    endtask

    task automatic recv_byte(output logic [7:0] d, input logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        send_bit(~ack);
    endtask

    // Loads the bytes the target should return, in order, for the next read.
    task automatic load_tx(input logic [7:0] v0, input logic [7:0] v1,
                           input logic [7:0] v2, input logic [7:0] v3);
        tx_data = v0;
        tx_vals = {v1, v2, v3};
    endtask

    logic       ack;
    logic [7:0] got;
    logic [7:0] exp_b[4];
    int         rx_base, tx_base;
    logic [6:0] r_addr;
    logic       r_rw, r_match;
    int         r_len;
    logic [7:0] r_last;

    initial begin
        reset = 1'b1; scl = 1'b1; m_low = 1'b0; tx_data = 8'h00;
        tick(4);
        check("reset_sda",      32'(sda === 1'b1), 32'd1);
        check("reset_rx_data",  32'(rx_data), 32'h00);
        check("reset_rx_valid", 32'(rx_valid), 32'd0);
        check("reset_tx_req",   32'(tx_req), 32'd0);
        check("reset_busy",     32'(busy), 32'd0);
        reset = 1'b0;
        tick(4);

        // Plain write of one byte.
        rx_base = rx_pulses;
        bus_start();
        send_byte(8'hA0, ack); check("wr_addr_ack", 32'(ack), 32'd1);
        send_byte(8'h3C, ack); check("wr_data_ack", 32'(ack), 32'd1);
        check("wr_busy_before_stop", 32'(busy), 32'd1);
        bus_stop(); tick(6);
        check("wr_rx_data", 32'(rx_data), 32'h3C);
        check("wr_rx_pulses", 32'(rx_pulses - rx_base), 32'd1);
        check("wr_busy_after_stop", 32'(busy), 32'd0);

        // Single read, master NACK.
        tx_base = tx_pulses;
        load_tx(8'hC5, 8'h00, 8'h00, 8'h00);
        bus_start();
        send_byte(8'hA1, ack); check("rd_addr_ack", 32'(ack), 32'd1);
        recv_byte(got, 1'b0);
        check("rd_byte", 32'(got), 32'hC5);
        check("rd_tx_pulses", 32'(tx_pulses - tx_base), 32'd1);
        tick(2 * Q);
        check("rd_sda_released_after_nack", 32'(sda === 1'b1), 32'd1);
        bus_stop(); tick(6);

        // Burst read: three ACKs then a NACK.
        tx_base = tx_pulses;
        for (int k = 0; k < 4; k++) exp_b[k] = 8'($urandom);
        load_tx(exp_b[0], exp_b[1], exp_b[2], exp_b[3]);
        bus_start();
        send_byte(8'hA1, ack); check("burst_addr_ack", 32'(ack), 32'd1);
        for (int k = 0; k < 4; k++) begin
            recv_byte(got, k < 3);
            check($sformatf("burst_byte%0d", k), 32'(got), 32'(exp_b[k]));
        end
        check("burst_tx_pulses", 32'(tx_pulses - tx_base), 32'd4);
        bus_stop(); tick(6);

        // Address mismatch: the target must stay silent.
        rx_base = rx_pulses; slave_drove = 1'b0; busy_seen = 1'b0;
        bus_start();
        send_byte(8'hB0, ack); check("mm_addr_nack", 32'(ack), 32'd0);
        send_byte(8'h55, ack); check("mm_data_nack", 32'(ack), 32'd0);
        bus_stop(); tick(6);
        check("mm_never_drove", 32'(slave_drove), 32'd0);
        check("mm_no_rx_valid", 32'(rx_pulses - rx_base), 32'd0);
        check("mm_busy_never", 32'(busy_seen), 32'd0);

        // Write, repeated START, then read.
        tx_base = tx_pulses;
        load_tx(8'h9E, 8'h00, 8'h00, 8'h00);
        bus_start();
        send_byte(8'hA0, ack); check("rs_wr_addr_ack", 32'(ack), 32'd1);
        send_byte(8'h01, ack); check("rs_wr_data_ack", 32'(ack), 32'd1);
        check("rs_rx_data", 32'(rx_data), 32'h01);
        bus_start();
        send_byte(8'hA1, ack); check("rs_rd_addr_ack", 32'(ack), 32'd1);
        check("rs_tx_req", 32'(tx_pulses - tx_base), 32'd1);
        recv_byte(got, 1'b0);
        check("rs_rd_byte", 32'(got), 32'h9E);
        bus_stop(); tick(6);

        // Reset in the middle of a data byte.
        rx_base = rx_pulses;
        bus_start();
        send_byte(8'hA0, ack); check("rst_addr_ack", 32'(ack), 32'd1);
        for (int i = 7; i >= 4; i--) send_bit(r_last_bit(8'h3C, i));
        reset = 1'b1; tick(1);
        check("rst_sda_released", 32'(sda === 1'b1), 32'd1);
        reset = 1'b0; tick(1);
        check("rst_busy_cleared", 32'(busy), 32'd0);
        for (int i = 3; i >= 0; i--) send_bit(r_last_bit(8'h3C, i));
        recv_bit(ack); check("rst_ignored_nack", 32'(ack), 32'd1);
        bus_stop(); tick(6);
        check("rst_no_rx_valid", 32'(rx_pulses - rx_base), 32'd0);
        bus_start();
        send_byte(8'hA0, ack); check("rst_again_addr_ack", 32'(ack), 32'd1);
        send_byte(8'h6B, ack); check("rst_again_data_ack", 32'(ack), 32'd1);
        bus_stop(); tick(6);
        check("rst_again_rx_data", 32'(rx_data), 32'h6B);
        check("rst_again_rx_pulses", 32'(rx_pulses - rx_base), 32'd1);

        // Randomized transfers against the transaction model.
        for (int t = 0; t < 10; t++) begin
            case ($urandom_range(0, 3))
                0, 1:    r_addr = SADR;
                2:       r_addr = 7'h00;
                default: r_addr = 7'($urandom);
            endcase
            r_rw  = 1'($urandom_range(0, 1));
            r_len = $urandom_range(1, 3);
`ifdef I2C_SLAVE_GENERAL_CALL_EN
            r_match = (r_addr == SADR) || (r_addr == 7'h00 && !r_rw);
`else
            r_match = (r_addr == SADR);
`endif
            for (int k = 0; k < 4; k++) exp_b[k] = 8'($urandom);
            rx_base = rx_pulses; tx_base = tx_pulses;
            slave_drove = 1'b0; busy_seen = 1'b0; r_last = rx_data;
            load_tx(exp_b[0], exp_b[1], exp_b[2], exp_b[3]);
            bus_start();
            send_byte({r_addr, r_rw}, ack);
            check($sformatf("rnd%0d_addr_ack", t), 32'(ack), 32'(r_match));
            if (r_match && r_rw) begin
                for (int k = 0; k < r_len; k++) begin
                    recv_byte(got, k < r_len - 1);
                    check($sformatf("rnd%0d_rd%0d", t, k), 32'(got), 32'(exp_b[k]));
                end
            end else begin
                for (int k = 0; k < r_len; k++) begin
                    send_byte(exp_b[k], ack);
                    check($sformatf("rnd%0d_wr%0d_ack", t, k), 32'(ack), 32'(r_match));
                end
                if (r_match) r_last = exp_b[r_len - 1];
            end
            bus_stop(); tick(6);
            check($sformatf("rnd%0d_rx_pulses", t), 32'(rx_pulses - rx_base),
                  (r_match && !r_rw) ? 32'(r_len) : 32'd0);
            check($sformatf("rnd%0d_tx_pulses", t), 32'(tx_pulses - tx_base),
                  (r_match && r_rw) ? 32'(r_len) : 32'd0);
            check($sformatf("rnd%0d_rx_data", t), 32'(rx_data), 32'(r_last));
            check($sformatf("rnd%0d_busy_seen", t), 32'(busy_seen), 32'(r_match));
            check($sformatf("rnd%0d_busy_end", t), 32'(busy), 32'd0);
            if (!r_match) check($sformatf("rnd%0d_silent", t), 32'(slave_drove), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

    function automatic logic r_last_bit(input logic [7:0] v, input int i);
        return v[i];
    endfunction

endmodule
